// File: rtl/eeg_block_packer.sv
// eeg_block_packer: gathers EEG samples into fixed-size blocks (one AES block
// each), tags every block with a unique nonce derived from a seed plus a
// running block count, and buffers finished blocks in a small
// first-word-fall-through FIFO for the downstream cipher.
//
// Handshakes: both ports use valid/ready. A transfer happens on a rising edge
// where valid and ready are both 1. A producer holds valid and its payload
// until the transfer. sample_ready depends only on internal state, never on
// sample_valid. blk_* payload stays stable while blk_valid=1 and blk_ready=0.
module eeg_block_packer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BLOCK_WIDTH  = 128,
  parameter int FIFO_DEPTH   = 4,
  parameter int NONCE_WIDTH  = 96
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic [NONCE_WIDTH-1:0]           nonce_seed,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  input  logic [SAMPLE_WIDTH-1:0]          sample_data,
  input  logic                             sample_last,
  output logic                             blk_valid,
  input  logic                             blk_ready,
  output logic [BLOCK_WIDTH-1:0]           blk_data,
  output logic [NONCE_WIDTH-1:0]           blk_nonce,
  output logic [$clog2(BLOCK_WIDTH/8):0]   blk_bytes,
  output logic                             blk_last,
  output logic [31:0]                      blocks_emitted,
  output logic                             nonce_exhausted
);

  localparam int LANES   = BLOCK_WIDTH / SAMPLE_WIDTH;
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BYTES_W = $clog2(BLOCK_WIDTH / 8) + 1;
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = ADDR_W + 1;

  // Assembly state for the block currently being filled.
  logic [LANE_W-1:0]      r_lane_cnt;
  logic [BLOCK_WIDTH-1:0] r_lanes;
  // Goes high on the first edge after reset so sample_ready never rises
  // combinationally on the release of rst.
  logic                   r_run;

  // Block FIFO: storage plus pointers and occupancy.
  logic [BLOCK_WIDTH-1:0] r_mem_data  [FIFO_DEPTH];
  logic [NONCE_WIDTH-1:0] r_mem_nonce [FIFO_DEPTH];
  logic [BYTES_W-1:0]     r_mem_bytes [FIFO_DEPTH];
  logic                   r_mem_last  [FIFO_DEPTH];
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  // Nonce bookkeeping.
  logic [31:0]            r_blocks_emitted;
  logic                   r_exhausted;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_accept;
  logic                   w_close;
  logic                   w_pop;
  logic [BLOCK_WIDTH-1:0] w_block;
  logic [BYTES_W-1:0]     w_bytes;
  logic [NONCE_WIDTH-1:0] w_nonce;

  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign sample_ready = r_run & ~w_full & ~r_exhausted;

  // clear masks both handshakes so a flush always wins.
  assign w_accept = sample_valid & sample_ready & ~clear;
  assign w_close  = w_accept & (sample_last | (r_lane_cnt == LANE_W'(LANES - 1)));
  assign w_pop    = blk_ready & ~w_empty & ~clear;

  // Lanes above the current one are always zero, so a closing block is
  // already zero-padded.
  assign w_bytes = BYTES_W'(((32'(r_lane_cnt) + 32'd1) * SAMPLE_WIDTH) / 8);
  assign w_nonce = nonce_seed + NONCE_WIDTH'(r_blocks_emitted);

  // Current assembly buffer with the offered sample dropped into its lane.
  always_comb begin
    w_block = r_lanes;
    w_block[r_lane_cnt*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_data;
  end

  // Lane counter and assembly buffer; a closed block restarts at lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_cnt <= '0;
      r_lanes    <= '0;
      r_run      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (clear) begin
        r_lane_cnt <= '0;
        r_lanes    <= '0;
      end else if (w_accept) begin
        if (w_close) begin
          r_lane_cnt <= '0;
          r_lanes    <= '0;
        end else begin
          r_lane_cnt <= r_lane_cnt + LANE_W'(1);
          r_lanes    <= w_block;
        end
      end
    end
  end

  // FIFO storage: a closing sample writes its finished block straight in.
  always_ff @(posedge clk) begin
    if (w_close) begin
      r_mem_data[r_wr_ptr]  <= w_block;
      r_mem_nonce[r_wr_ptr] <= w_nonce;
      r_mem_bytes[r_wr_ptr] <= w_bytes;
      r_mem_last[r_wr_ptr]  <= sample_last;
    end
  end

  // FIFO pointers and occupancy; a push and a pop on one edge cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_close) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      if (w_close && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_close && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Block counter; the last nonce value is spent once the counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blocks_emitted <= '0;
      r_exhausted      <= 1'b0;
    end else if (clear) begin
      r_blocks_emitted <= '0;
      r_exhausted      <= 1'b0;
    end else if (w_close) begin
      if (r_blocks_emitted == 32'hFFFF_FFFF) r_exhausted <= 1'b1;
      else                                   r_blocks_emitted <= r_blocks_emitted + 32'd1;
    end
  end

  // Head of the FIFO; payload reads as zero whenever nothing is buffered.
  assign blk_valid       = ~w_empty;
  assign blk_data        = blk_valid ? r_mem_data[r_rd_ptr]  : '0;
  assign blk_nonce       = blk_valid ? r_mem_nonce[r_rd_ptr] : '0;
  assign blk_bytes       = blk_valid ? r_mem_bytes[r_rd_ptr] : '0;
  assign blk_last        = blk_valid ? r_mem_last[r_rd_ptr]  : 1'b0;
  assign blocks_emitted  = r_blocks_emitted;
  assign nonce_exhausted = r_exhausted;

endmodule

// File: doc/eeg_block_packer.md
EEG_BLOCK_PACKER -- requirements
Module: eeg_block_packer

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 16, bits per EEG sample.
REQ-002 Parameter BLOCK_WIDTH, default 128, bits per packed block (AES block size); BLOCK_WIDTH SHALL be a multiple of SAMPLE_WIDTH and of 8, giving LANES = BLOCK_WIDTH/SAMPLE_WIDTH (default 8).
REQ-003 Parameter FIFO_DEPTH, default 4, number of buffered output blocks, a power of two and at least 2.
REQ-004 Parameter NONCE_WIDTH, default 96, width of the per-block nonce.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Port list (name direction width meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous flush of all state
- nonce_seed  in  NONCE_WIDTH  base nonce
- sample_valid  in  1  sample offered
- sample_ready  out  1  sample accepted when valid&ready
- sample_data  in  SAMPLE_WIDTH  EEG sample
- sample_last  in  1  final sample of a record
- blk_valid  out  1  FIFO head valid
- blk_ready  in  1  consumer takes head when valid&ready
- blk_data  out  BLOCK_WIDTH  packed block
- blk_nonce  out  NONCE_WIDTH  nonce for this block
- blk_bytes  out  $clog2(BLOCK_WIDTH/8)+1  valid bytes in block
- blk_last  out  1  block closes a record
- blocks_emitted  out  32  blocks written to FIFO
- nonce_exhausted  out  1  sticky, counter spent

Function
REQ-007 Sample k of a block (k=0..LANES-1, arrival order) SHALL occupy blk_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-008 A lane counter (0..LANES-1) SHALL advance on each accepted sample and return to 0 after a block is closed.
REQ-009 A block SHALL close on the edge accepting a sample that fills lane LANES-1 or that carries sample_last=1.
REQ-010 A closed block SHALL be written into the FIFO on that same edge with unfilled lanes zero, blk_bytes = filled_lanes*SAMPLE_WIDTH/8, blk_last = sample_last of the closing sample.
REQ-011 blk_nonce SHALL equal nonce_seed + blocks_emitted, with blocks_emitted zero-extended and sampled at write time, modulo 2^NONCE_WIDTH; blocks_emitted SHALL then increment by 1.
REQ-012 The FIFO SHALL be first-word-fall-through: blk_valid SHALL go high on the edge after the block is written if the FIFO was empty (one-cycle latency from closing sample to blk_valid).
REQ-013 blk_data, blk_nonce, blk_bytes and blk_last SHALL stay stable while blk_valid=1 and blk_ready=0.
REQ-014 sample_ready SHALL be 1 only when the FIFO holds fewer than FIFO_DEPTH entries and nonce_exhausted=0; a partially filled block waits without loss while sample_ready=0.
REQ-015 A write and a pop on the same edge SHALL leave the occupancy unchanged; a pop from an empty FIFO SHALL be ignored.
REQ-016 When a block is written with blocks_emitted = 2^32-1, nonce_exhausted SHALL set and blocks_emitted SHALL hold at 2^32-1; FIFO contents SHALL still drain.
REQ-017 clear=1 SHALL empty the FIFO, zero lanes, lane counter and blocks_emitted, and drop nonce_exhausted on the next edge, with priority over every simultaneous handshake.
REQ-018 sample_last=1 on a sample landing in lane 0 SHALL emit a one-sample block with blk_bytes = SAMPLE_WIDTH/8.

Reset
REQ-019 On rst=1 all state SHALL clear immediately: blk_valid=0, sample_ready=0, blocks_emitted=0, nonce_exhausted=0, FIFO empty, lane counter 0.
REQ-020 sample_ready SHALL rise on the first edge after rst deasserts; a partial block interrupted by rst SHALL be discarded and never emitted.

Verification
REQ-021 Full block: seed=96'h1, samples 16'h0001..16'h0008, blk_ready=1 -> one block 128'h0008_0007_..._0001, nonce 96'h1, bytes 16, last 0, valid one cycle after the 8th accept.
REQ-022 Partial record: 3 samples 16'hA1,16'hA2,16'hA3 with last on the 3rd -> blk_data 128'h00A3_00A2_00A1 zero-padded, bytes 6, last 1; next full block nonce = seed+1.
REQ-023 Backpressure: blk_ready=0, 40 samples offered -> 4 blocks buffered, sample_ready low after the 32nd accept, sample 33 held; blk_ready=1 -> 5 blocks out in order with nonces seed..seed+4.
REQ-024 Simultaneous push/pop with FIFO at 3 of 4 -> occupancy stays 3, sample_ready stays 1.
REQ-025 Exhaustion: force blocks_emitted to 32'hFFFF_FFFE, emit 2 blocks -> nonce_exhausted=1, sample_ready=0, counter holds; clear -> all zero, sample_ready=1.
REQ-026 rst asserted mid-block after 5 samples -> outputs zero immediately; 8 new samples after release -> one block with nonce = seed, none of the first 5 samples.
